cordic: RTL and testbench

//  Iterative 32-bit fixed-point CORDIC engine; one micro-rotation per clock.

---
 rtl/cordic_if.sv | 26 ++
 rtl/cordic.sv | 186 ++++++++++++++++++
 tb/tb_cordic.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_if.sv
// Handshake and data bundle between a controller and the cordic engine.
// The controller side is the master; the engine side is the slave.
interface cordic_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] in_angle;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_y;
  logic                    ready;
  logic                    done;
  logic signed [WIDTH-1:0] out_angle;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;

  modport master (
    output start, mode, in_angle, in_x, in_y,
    input  ready, done, out_angle, out_x, out_y
  );

  modport slave (
    input  start, mode, in_angle, in_x, in_y,
    output ready, done, out_angle, out_x, out_y
  );
endinterface

// File: rtl/cordic.sv
// Iterative fixed-point CORDIC engine, one micro-rotation per clock.
// mode=0 rotates (x,y) by the angle; mode=1 drives y to zero and returns the
// angle and the gain-scaled magnitude. Angle scale: 2^(WIDTH-1) == pi/2.
// Timeline from the accepting edge: ITERATIONS iteration cycles, one output
// conversion cycle (done rises), then one DONE cycle before ready returns.
module cordic #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ITERATIONS = 32,
  parameter int unsigned GUARD      = 2
) (
  input logic      clk,
  input logic      reset,
  cordic_if.slave  bus
);
  localparam int unsigned IW        = WIDTH + GUARD;
  localparam int unsigned CW        = $clog2(ITERATIONS + 1);
  // ROM holds 32-bit-scale constants; other widths rescale by shifting.
  localparam int          AtanShift = int'(WIDTH) - 32;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_mode;
  logic                    r_xneg;
  logic                    r_yneg;
  logic signed [IW-1:0]    r_x;
  logic signed [IW-1:0]    r_y;
  logic signed [IW-1:0]    r_z;
  logic                    r_ready;
  logic                    r_done;
  logic signed [WIDTH-1:0] r_out_angle;
  logic signed [WIDTH-1:0] r_out_x;
  logic signed [WIDTH-1:0] r_out_y;

  logic                    w_d_pos;
  logic signed [IW-1:0]    w_x_sh;
  logic signed [IW-1:0]    w_y_sh;
  logic signed [IW-1:0]    w_atan;
  logic signed [IW-1:0]    w_x_nxt;
  logic signed [IW-1:0]    w_y_nxt;
  logic signed [IW-1:0]    w_z_nxt;
  logic signed [WIDTH-1:0] w_angle_res;

  // round(atan(2^-i) * 2^32 / pi); entry 0 is exactly pi/4.
  function automatic logic signed [IW-1:0] atan_rom(input logic [CW-1:0] idx);
    logic [31:0] v;
    logic [63:0] s;
    case (int'(idx))
      0:       v = 32'd1073741824;
      1:       v = 32'd633866811;
      2:       v = 32'd334917815;
      3:       v = 32'd170009512;
      4:       v = 32'd85334662;
      5:       v = 32'd42708931;
      6:       v = 32'd21359677;
      7:       v = 32'd10680490;
      8:       v = 32'd5340327;
      9:       v = 32'd2670173;
      10:      v = 32'd1335088;
      11:      v = 32'd667544;
      12:      v = 32'd333772;
      13:      v = 32'd166886;
      14:      v = 32'd83443;
      15:      v = 32'd41722;
      16:      v = 32'd20861;
      17:      v = 32'd10430;
      18:      v = 32'd5215;
      19:      v = 32'd2608;
      20:      v = 32'd1304;
      21:      v = 32'd652;
      22:      v = 32'd326;
      23:      v = 32'd163;
      24:      v = 32'd81;
      25:      v = 32'd41;
      26:      v = 32'd20;
      27:      v = 32'd10;
      28:      v = 32'd5;
      29:      v = 32'd3;
      30:      v = 32'd1;
      31:      v = 32'd1;
      default: v = 32'd0;
    endcase
    s = {32'd0, v};
    if (AtanShift >= 0) s = s << AtanShift;
    else                s = s >> (-AtanShift);
    return IW'(s);
  endfunction

  // Clamp a guarded internal value into the signed WIDTH-bit port range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if ((&v[IW-1:WIDTH-1]) || !(|v[IW-1:WIDTH-1])) return v[WIDTH-1:0];
    else if (v[IW-1])                             return {1'b1, {(WIDTH-1){1'b0}}};
    else                                          return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // One micro-rotation on the current x/y/z using the iteration count as shift.
  always_comb begin
    w_x_sh  = r_x >>> r_cnt;
    w_y_sh  = r_y >>> r_cnt;
    w_atan  = atan_rom(r_cnt);
    w_d_pos = r_mode ? r_y[IW-1] : ~r_z[IW-1];
    if (w_d_pos) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end
  end

  // Vectoring from the left half-plane cannot converge; report +-pi/2 by y sign.
  always_comb begin
    w_angle_res = sat(r_z);
    if (r_mode && r_xneg) begin
      w_angle_res = r_yneg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Control FSM plus datapath registers and registered handshake/outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_xneg      <= 1'b0;
      r_yneg      <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_out_angle <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state <= StBusy;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= bus.mode;
            r_xneg  <= bus.in_x[WIDTH-1];
            r_yneg  <= bus.in_y[WIDTH-1];
            r_x     <= {{GUARD{bus.in_x[WIDTH-1]}}, bus.in_x};
            r_y     <= {{GUARD{bus.in_y[WIDTH-1]}}, bus.in_y};
            r_z     <= bus.mode ? '0 : {{GUARD{bus.in_angle[WIDTH-1]}}, bus.in_angle};
          end
        end
        StBusy: begin
          if (r_cnt == CW'(ITERATIONS)) begin
            // All micro-rotations applied: convert and publish.
            r_out_angle <= w_angle_res;
            r_out_x     <= sat(r_x);
            r_out_y     <= sat(r_y);
            r_done      <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_z   <= w_z_nxt;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.done      = r_done;
  assign bus.out_angle = r_out_angle;
  assign bus.out_x     = r_out_x;
  assign bus.out_y     = r_out_y;
endmodule

// File: tb/tb_cordic.sv
// Directed bench for the cordic engine with hand-computed expected results.
// K*2^30 = 1768195363, K*2^30/sqrt(2) = 1250302932 (K = 1.6467602581).
module tb_cordic;
  localparam int     W   = 32;
  localparam longint TOL = 512;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cordic_if #(.WIDTH(W)) u_if ();

  cordic #(.WIDTH(W), .ITERATIONS(32), .GUARD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  function automatic longint adiff(input logic signed [W-1:0] a, input longint e);
    longint d;
    d = longint'(a) - e;
    return (d < 0) ? -d : d;
  endfunction

  // Waits for ready, issues a one-cycle start, returns clocks to done (-1 on timeout).
  task automatic run_op(input logic m, input logic signed [W-1:0] a,
                        input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                        output int lat);
    @(negedge clk);
    for (int k = 0; k < 50 && !u_if.ready; k++) @(negedge clk);
    u_if.mode = m; u_if.in_angle = a; u_if.in_x = x; u_if.in_y = y; u_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_tests++;
    if (u_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", u_if.ready); end
    n_tests++;
    if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", u_if.done); end
    n_tests++;
    if (u_if.out_x !== 32'sd0 || u_if.out_y !== 32'sd0 || u_if.out_angle !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_outputs got x=%0d y=%0d a=%0d want 0 0 0",
               u_if.out_x, u_if.out_y, u_if.out_angle);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rotation();
    logic signed [W-1:0] vx [6] = '{32'sd1073741824, 32'sd1073741824, 32'sd1073741824,
                                    32'sd1073741824, 32'sd1073741824, 32'sd0};
    logic signed [W-1:0] vy [6] = '{32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd1073741824};
    logic signed [W-1:0] va [6] = '{32'sd0, 32'sd715827883, 32'sd1073741824,
                                    32'sh7FFF_FFFF, -32'sd1073741824, 32'sd1073741824};
    longint ex [6] = '{1768195363, 1531302103, 1250302932, 1, 1250302932, -1250302932};
    longint ey [6] = '{0, 884097682, 1250302932, 1768195363, -1250302932, 1250302932};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, va[i], vx[i], vy[i], lat);
      n_tests++;
      if (lat != 33) begin n_fail++; $display("FAIL rot%0d_latency got %0d want 33", i, lat); end
      n_tests++;
      if (adiff(u_if.out_x, ex[i]) > TOL) begin
        n_fail++; $display("FAIL rot%0d_x got %0d want %0d", i, u_if.out_x, ex[i]);
      end
      n_tests++;
      if (adiff(u_if.out_y, ey[i]) > TOL) begin
        n_fail++; $display("FAIL rot%0d_y got %0d want %0d", i, u_if.out_y, ey[i]);
      end
      n_tests++;
      if (adiff(u_if.out_angle, 0) > TOL) begin
        n_fail++; $display("FAIL rot%0d_residual got %0d want 0", i, u_if.out_angle);
      end
    end
  endtask

  task automatic test_vectoring();
    logic signed [W-1:0] vx [6] = '{32'sd0, 32'sd1073741824, 32'sd1073741824,
                                    32'sd1073741824, 32'sd0, 32'sd402653184};
    logic signed [W-1:0] vy [6] = '{32'sd1073741824, 32'sd1073741824, 32'sd0,
                                    -32'sd1073741824, -32'sd1073741824, 32'sd536870912};
    longint ea [6] = '{2147483647, 1073741824, 0, -1073741824, -64'sd2147483648, 1267733622};
    longint ex [6] = '{1768195363, 2147483647, 1768195363, 2147483647, 1768195363, 1105122102};
    int lat;
    for (int i = 0; i < 6; i++) begin
      // A nonzero angle input must be ignored in vectoring mode.
      run_op(1'b1, 32'sd12345678, vx[i], vy[i], lat);
      n_tests++;
      if (lat != 33) begin n_fail++; $display("FAIL vec%0d_latency got %0d want 33", i, lat); end
      n_tests++;
      if (adiff(u_if.out_angle, ea[i]) > TOL) begin
        n_fail++; $display("FAIL vec%0d_angle got %0d want %0d", i, u_if.out_angle, ea[i]);
      end
      n_tests++;
      if (adiff(u_if.out_x, ex[i]) > TOL) begin
        n_fail++; $display("FAIL vec%0d_mag got %0d want %0d", i, u_if.out_x, ex[i]);
      end
      n_tests++;
      if (adiff(u_if.out_y, 0) > TOL) begin
        n_fail++; $display("FAIL vec%0d_y got %0d want 0", i, u_if.out_y);
      end
    end
  endtask

  task automatic test_vec_negx();
    logic signed [W-1:0] vx [3] = '{-32'sd1073741824, -32'sd1073741824, -32'sd100};
    logic signed [W-1:0] vy [3] = '{32'sd5, -32'sd5, 32'sd0};
    logic signed [W-1:0] ea [3] = '{32'sh7FFF_FFFF, 32'sh8000_0000, 32'sh7FFF_FFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, 32'sd0, vx[i], vy[i], lat);
      n_tests++;
      if (u_if.out_angle !== ea[i]) begin
        n_fail++; $display("FAIL negx%0d_angle got %0d want %0d", i, u_if.out_angle, ea[i]);
      end
    end
  endtask

  // Start held high through done: one pulse, ready back the cycle after.
  task automatic test_handshake();
    int lat = -1;
    int pulses = 0;
    @(negedge clk);
    for (int k = 0; k < 50 && !u_if.ready; k++) @(negedge clk);
    u_if.mode = 1'b0; u_if.in_angle = 32'sd1073741824;
    u_if.in_x = 32'sd1073741824; u_if.in_y = 32'sd0; u_if.start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done) begin lat = i; break; end
    end
    n_tests++;
    if (lat != 33) begin n_fail++; $display("FAIL hs_latency got %0d want 33", lat); end
    n_tests++;
    if (u_if.ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_at_done got %b want 0", u_if.ready); end
    @(posedge clk);
    #1;
    n_tests++;
    if (u_if.done !== 1'b0 || u_if.ready !== 1'b1) begin
      n_fail++; $display("FAIL hs_after_done got done=%b ready=%b want 0 1", u_if.done, u_if.ready);
    end
    @(negedge clk);
    u_if.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL hs_extra_done got %0d want 0", pulses); end
  endtask

  // Start and new data during BUSY are ignored; outputs hold the previous result.
  task automatic test_busy_ignore();
    int lat = -1;
    int hold_bad = 0;
    int pulses = 0;
    @(negedge clk);
    for (int k = 0; k < 50 && !u_if.ready; k++) @(negedge clk);
    u_if.mode = 1'b0; u_if.in_angle = 32'sd0;
    u_if.in_x = 32'sd1073741824; u_if.in_y = 32'sd0; u_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done) begin lat = i; break; end
      if (adiff(u_if.out_x, 1250302932) > TOL || adiff(u_if.out_y, 1250302932) > TOL) hold_bad++;
      if (i == 5) begin
        u_if.start = 1'b1; u_if.mode = 1'b1; u_if.in_angle = 32'sd1073741824;
        u_if.in_x = -32'sd5; u_if.in_y = 32'sd7;
      end
      if (i == 8) u_if.start = 1'b0;
    end
    n_tests++;
    if (hold_bad != 0) begin n_fail++; $display("FAIL busy_hold got %0d bad cycles want 0", hold_bad); end
    n_tests++;
    if (lat != 33) begin n_fail++; $display("FAIL busy_latency got %0d want 33", lat); end
    n_tests++;
    if (adiff(u_if.out_x, 1768195363) > TOL || adiff(u_if.out_y, 0) > TOL) begin
      n_fail++; $display("FAIL busy_result got x=%0d y=%0d want 1768195363 0", u_if.out_x, u_if.out_y);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL busy_start_taken got %0d dones want 0", pulses); end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    int pulses = 0;
    @(negedge clk);
    for (int k = 0; k < 50 && !u_if.ready; k++) @(negedge clk);
    u_if.mode = 1'b0; u_if.in_angle = 32'sd1073741824;
    u_if.in_x = 32'sd1073741824; u_if.in_y = 32'sd0; u_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (u_if.ready !== 1'b1 || u_if.done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hs got ready=%b done=%b want 1 0", u_if.ready, u_if.done);
    end
    n_tests++;
    if (u_if.out_x !== 32'sd0 || u_if.out_y !== 32'sd0 || u_if.out_angle !== 32'sd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got x=%0d y=%0d a=%0d want 0 0 0",
               u_if.out_x, u_if.out_y, u_if.out_angle);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL rstmid_aborted got %0d dones want 0", pulses); end
    run_op(1'b1, 32'sd0, 32'sd402653184, 32'sd536870912, lat);
    n_tests++;
    if (lat != 33) begin n_fail++; $display("FAIL rstmid_next_latency got %0d want 33", lat); end
    n_tests++;
    if (adiff(u_if.out_angle, 1267733622) > TOL || adiff(u_if.out_x, 1105122102) > TOL) begin
      n_fail++;
      $display("FAIL rstmid_next_result got a=%0d x=%0d want 1267733622 1105122102",
               u_if.out_angle, u_if.out_x);
    end
  endtask

  initial begin
    u_if.start    = 1'b0;
    u_if.mode     = 1'b0;
    u_if.in_angle = '0;
    u_if.in_x     = '0;
    u_if.in_y     = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_rotation();
    test_vectoring();
    test_vec_negx();
    test_handshake();
    test_busy_ignore();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
